// File: rtl/foo_pkg.sv
// Shared types for the foo adder pipeline: operand struct and packer FSM states.
package foo_pkg;

   localparam int FOO_WORD_WIDTH = 32;
   localparam int FOO_S_WIDTH    = 64;

   // a sits in the upper half so the struct drops straight onto the pipeline's s input
   typedef struct packed {
      logic [FOO_WORD_WIDTH-1:0] a;
      logic [FOO_WORD_WIDTH-1:0] b;
   } foo_s_t;

   typedef enum logic {
      EXPECT_A,
      EXPECT_B
   } foo_pack_state_e;

endpackage

// File: rtl/foo_s_out_slot.sv
// Single-entry valid/ready output register; a load may replace a struct leaving
// in the same cycle, so streaming runs without bubbles.
module foo_s_out_slot #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         padded_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         padded_o,
   output logic         valid_o,
   output logic         can_load_o
);

   logic [W-1:0] data_q;
   logic         padded_q;
   logic         valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '0;
         padded_q <= 1'b0;
         valid_q  <= 1'b0;
      end else if (load_i) begin
         data_q   <= data_i;
         padded_q <= padded_i;
         valid_q  <= 1'b1;
      end else if (valid_q && ready_i) begin
         // data and padded keep their last values once consumed
         valid_q  <= 1'b0;
      end
   end

   assign data_o     = data_q;
   assign padded_o   = padded_q;
   assign valid_o    = valid_q;
   assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/foo_s_packer.sv
// Packs pairs of input words into {a, b} structs for the foo pipeline; an odd
// trailing word is emitted with b = PAD_VALUE and the padded flag set.
module foo_s_packer
   import foo_pkg::*;
#(
   parameter int                    WORD_WIDTH  = 32,
   parameter logic [WORD_WIDTH-1:0] PAD_VALUE   = '0,
   parameter int                    COUNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORD_WIDTH-1:0]   in_word,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [2*WORD_WIDTH-1:0] s_out,
   output logic                    s_out_padded,
   output logic                    s_out_valid,
   input  logic                    s_out_ready,
   output logic [COUNT_WIDTH-1:0]  struct_count
);

   foo_pack_state_e         state_q, state_d;
   logic [WORD_WIDTH-1:0]   a_hold_q, a_hold_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                    in_fire;
   logic                    out_fire;
   logic                    emit;
   logic [2*WORD_WIDTH-1:0] emit_data;
   logic                    emit_pad;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = s_out_valid && s_out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EXPECT_A;
         a_hold_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_hold_q <= a_hold_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_hold_d  = a_hold_q;
      emit      = 1'b0;
      emit_data = '0;
      emit_pad  = 1'b0;
      if (in_fire) begin
         case (state_q)
            EXPECT_A: begin
               if (in_last) begin
                  emit      = 1'b1;
                  emit_data = {in_word, PAD_VALUE};
                  emit_pad  = 1'b1;
               end else begin
                  a_hold_d  = in_word;
                  state_d   = EXPECT_B;
               end
            end
            EXPECT_B: begin
               // in_last is irrelevant here: the burst closes on an even word
               emit      = 1'b1;
               emit_data = {a_hold_q, in_word};
               state_d   = EXPECT_A;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_fire) cnt_d = cnt_q + COUNT_WIDTH'(1);
   end

   foo_s_out_slot #(
      .W (2*WORD_WIDTH)
   ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load_i     (emit),
      .data_i     (emit_data),
      .padded_i   (emit_pad),
      .ready_i    (s_out_ready),
      .data_o     (s_out),
      .padded_o   (s_out_padded),
      .valid_o    (s_out_valid),
      .can_load_o (in_ready)
   );

   assign struct_count = cnt_q;

endmodule
